cal_field_counter: RTL

Parametrised calendar/time field counter: the generic successor to the single-purpose day counter, used for seconds, minutes, hours, day, month and year digits of the clock. It holds one field value in [MIN_VAL, max_val], advances on a cascade tick from the next-lower field and emits a wrap carry to the next-higher field. It supports manual up/down adjustment with optional hold-to-repeat, a parallel load, and clamping when max_val shrinks at run time (for example, day 31 when the month changes to 30).

---
 rtl/clock_pkg.sv | 47 ++++
 rtl/btn_repeat.sv | 105 ++++++++++
 rtl/cal_field_counter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants and types for the clock's calendar/time field counters.
//   - Field widths and lowest legal value for each clock field.
//   - Default auto-repeat timing for the adjust buttons.
//   - Repeat FSM state type used by btn_repeat.
//   - cnt_width(): width of a counter that must hold values 0 .. max(a,b)-1.
// -----------------------------------------------------------------------------
package clock_pkg;

  // Field widths
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MINUTE_W = 6;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned DAY_W    = 6;
  localparam int unsigned MONTH_W  = 4;
  localparam int unsigned YEAR_W   = 7;

  // Lowest legal value per field
  localparam int unsigned SEC_MIN_VAL    = 0;
  localparam int unsigned MINUTE_MIN_VAL = 0;
  localparam int unsigned HOUR_MIN_VAL   = 0;
  localparam int unsigned DAY_MIN_VAL    = 1;
  localparam int unsigned MONTH_MIN_VAL  = 1;
  localparam int unsigned YEAR_MIN_VAL   = 0;

  // Button auto-repeat timing (clock cycles)
  localparam int unsigned REPEAT_DELAY_DEFAULT = 25_000_000;
  localparam int unsigned REPEAT_RATE_DEFAULT  = 5_000_000;

  // Repeat FSM states
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Counter width able to hold 0 .. max(a,b)-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// -----------------------------------------------------------------------------
// btn_repeat
// Press-edge detection plus hold-to-repeat timing for the field adjust buttons.
// A new press issues one step immediately; if the button stays held, a second
// step follows REPEAT_DELAY cycles later and then one every REPEAT_RATE cycles.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   adjust mode (buttons are ignored while low)
//   up       in   increment button level
//   down     in   decrement button level
//   cancel   in   abort the current hold (parallel load); the FSM waits for a
//                 fresh press afterwards
//   step     out  combinational step strobe for the current cycle
//   step_up  out  step direction (1 = up, 0 = down), valid with step
// -----------------------------------------------------------------------------
module btn_repeat
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic up,
  input  logic down,
  input  logic cancel,
  output logic step,
  output logic step_up
);

  localparam int unsigned      CNT_W      = cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  rpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q;   // qualified direction was active last cycle
  logic             up_q;    // up level last cycle (direction when act_q)
  logic             act;
  logic             press;

  // Exactly one of up/down pressed, and only while adjusting.
  assign act     = enable & (up ^ down);
  // New press: direction just became active, or flipped polarity.
  assign press   = act & ~(act_q & (up_q == up));
  assign step_up = up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act;
      up_q    <= up;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (!act || cancel) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else if (press) begin
      state_d = RPT_DELAY;
      cnt_d   = '0;
      step    = 1'b1;
    end else begin
      case (state_q)
        RPT_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            state_d = RPT_REPEAT;
            cnt_d   = '0;
            step    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == RATE_LAST) begin
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE with the button still held (e.g. after a load): wait for
          // a release and a fresh press.
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cal_field_counter.sv
// -----------------------------------------------------------------------------
// cal_field_counter
// One calendar/time field (sec, min, hour, day, month, year) of the clock.
// Holds a value in [MIN_VAL, emax] with emax = max(max_val, MIN_VAL); advances
// on a cascade tick and emits a one-cycle carry when the tick wraps; supports
// manual up/down adjustment, parallel load, and clamps down when max_val
// shrinks at run time.
//
// Build option
//   CAL_FIELD_AUTOREPEAT_EN  defined: held buttons auto-repeat through
//                            btn_repeat (REPEAT_DELAY / REPEAT_RATE).
//                            undefined: one step per press, no repeat logic.
//
// Ports
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   tick        in   cascade pulse from the next-lower field
//   manual_set  in   adjust mode enable (level)
//   up / down   in   adjust buttons (levels, debounced)
//   load        in   parallel load strobe
//   load_val    in   value to load (clamped into range)
//   max_val     in   current upper bound (may change at run time)
//   value       out  field value (registered)
//   carry_out   out  one-cycle pulse on tick-driven wrap (registered)
//   adj_step    out  one-cycle pulse on each manual step (registered)
// -----------------------------------------------------------------------------
module cal_field_counter
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH        = 6,
  parameter int unsigned MIN_VAL      = 1,
  parameter int unsigned RESET_VAL    = 1,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             manual_set,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] value,
  output logic             carry_out,
  output logic             adj_step
);

  // Reject unusable parameter sets at elaboration.
  if ((RESET_VAL < MIN_VAL) || ((RESET_VAL >> WIDTH) != 0) ||
      (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_cfg
    $error("cal_field_counter: illegal parameter combination");
  end

  // One extra bit so value+1 cannot overflow when emax = 2^WIDTH-1.
  localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_VAL);

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             adj_q, adj_d;

  logic             step;
  logic             step_up;

  // ---------------------------------------------------------------------------
  // Manual step source
  // ---------------------------------------------------------------------------
`ifdef CAL_FIELD_AUTOREPEAT_EN
  btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_btn_repeat (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (manual_set),
    .up      (up),
    .down    (down),
    .cancel  (load),
    .step    (step),
    .step_up (step_up)
  );
`else
  logic press_act;
  logic press_act_q;
  logic press_up_q;

  assign press_act = manual_set & (up ^ down);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_act_q <= 1'b0;
      press_up_q  <= 1'b0;
    end else begin
      press_act_q <= press_act;
      press_up_q  <= up;
    end
  end

  // One step per new press (or polarity change); a concurrent load wins.
  assign step    = press_act & ~(press_act_q & (press_up_q == up)) & ~load;
  assign step_up = up;
`endif

  // ---------------------------------------------------------------------------
  // Value datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] val_x;
  logic [WIDTH:0] max_x;
  logic [WIDTH:0] emax_x;
  logic [WIDTH:0] load_x;
  logic [WIDTH:0] inc_x;
  logic [WIDTH:0] dec_x;
  logic [WIDTH:0] next_x;

  assign val_x  = {1'b0, value_q};
  assign max_x  = {1'b0, max_val};
  assign load_x = {1'b0, load_val};
  assign emax_x = (max_x > MIN_X) ? max_x : MIN_X;

  // Up wraps from emax (or anything above it) to MIN_VAL.
  assign inc_x  = (val_x >= emax_x) ? MIN_X : (val_x + 1'b1);
  // Down wraps from MIN_VAL to emax; an out-of-range value also lands on emax.
  assign dec_x  = ((val_x <= MIN_X) || (val_x > emax_x)) ? emax_x : (val_x - 1'b1);

  always_comb begin
    next_x  = val_x;
    carry_d = 1'b0;
    adj_d   = 1'b0;
    if (load) begin
      if (load_x < MIN_X) begin
        next_x = MIN_X;
      end else if (load_x > emax_x) begin
        next_x = emax_x;
      end else begin
        next_x = load_x;
      end
    end else if (step) begin
      next_x = step_up ? inc_x : dec_x;
      adj_d  = 1'b1;
    end else if (tick && !manual_set) begin
      next_x  = inc_x;
      carry_d = (val_x >= emax_x);
    end else if (val_x > emax_x) begin
      next_x = emax_x;
    end
    value_d = WIDTH'(next_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= WIDTH'(RESET_VAL);
      carry_q <= 1'b0;
      adj_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
      adj_q   <= adj_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_q;
  assign adj_step  = adj_q;

endmodule
